// File: rtl/m68k_bus_cycle.sv
// 68000 asynchronous bus-cycle master: turns a REQ/ACK transaction into AS/UDS/LDS/RW
// sequencing paced by MC-clock edge strobes, with a DTACK watchdog.
module m68k_bus_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_sysclk,
  input  logic        i_reset_n,
  input  logic        i_mcclk_rising,
  input  logic        i_mcclk_falling,
  input  logic        i_dtack_latch,
  input  logic        i_req,
  input  logic        i_req_rw,
  input  logic        i_req_word,
  input  logic [23:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_busy,
  output logic        o_ack,
  output logic        o_timeout,
  output logic [15:0] o_rdata,
  output logic [22:0] o_m68k_a,
  input  logic [15:0] i_m68k_d_in,
  output logic [15:0] o_m68k_d_out,
  output logic        o_m68k_d_oe,
  output logic        o_m68k_as_n,
  output logic        o_m68k_uds_n,
  output logic        o_m68k_lds_n,
  output logic        o_m68k_rw
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_ASSERT = 3'd2,
    S_DATA   = 3'd3,
    S_WAIT   = 3'd4,
    S_END    = 3'd5
  } state_t;

  state_t      r_state, w_state;
  logic        r_rw, w_rw;
  logic        r_word, w_word;
  logic        r_a0, w_a0;
  logic [15:0] r_wdata, w_wdata;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_dtack_seen, w_dtack_seen;
  logic        r_to_flag, w_to_flag;
  logic        r_busy, w_busy;
  logic        r_ack, w_ack;
  logic        r_timeout, w_timeout;
  logic [15:0] r_rdata, w_rdata;
  logic [22:0] r_a, w_a;
  logic [15:0] r_d_out, w_d_out;
  logic        r_d_oe, w_d_oe;
  logic        r_as_n, w_as_n;
  logic        r_uds_n, w_uds_n;
  logic        r_lds_n, w_lds_n;
  logic        r_rw_out, w_rw_out;
  logic [1:0]  w_lanes;

  // Returns {uds_n, lds_n}: a word uses both lanes, a byte uses UDS for even addresses.
  function automatic logic [1:0] lane_sel(input logic word, input logic a0);
    if (word) begin
      lane_sel = 2'b00;
    end else if (a0) begin
      lane_sel = 2'b10;
    end else begin
      lane_sel = 2'b01;
    end
  endfunction

  assign w_lanes = lane_sel(r_word, r_a0);

  // Next-state and next-output decode; every state advances only on its own strobe.
  always_comb begin
    w_state      = r_state;
    w_rw         = r_rw;
    w_word       = r_word;
    w_a0         = r_a0;
    w_wdata      = r_wdata;
    w_cnt        = r_cnt;
    w_dtack_seen = r_dtack_seen;
    w_to_flag    = r_to_flag;
    w_busy       = r_busy;
    w_ack        = 1'b0;
    w_timeout    = 1'b0;
    w_rdata      = r_rdata;
    w_a          = r_a;
    w_d_out      = r_d_out;
    w_d_oe       = r_d_oe;
    w_as_n       = r_as_n;
    w_uds_n      = r_uds_n;
    w_lds_n      = r_lds_n;
    w_rw_out     = r_rw_out;
    case (r_state)
      S_IDLE: begin
        if (i_req && i_mcclk_rising) begin
          w_state  = S_ADDR;
          w_rw     = i_req_rw;
          w_word   = i_req_word;
          w_a0     = i_req_addr[0];
          w_wdata  = i_req_wdata;
          w_a      = i_req_addr[23:1];
          w_busy   = 1'b1;
          w_rw_out = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_ADDR: begin
        if (i_mcclk_falling) begin
          w_state = S_ASSERT;
          w_as_n  = 1'b0;
          if (r_rw) begin
            w_uds_n = w_lanes[1];
            w_lds_n = w_lanes[0];
          end else begin
            w_rw_out = 1'b0;
          end
        end else begin
          w_state = S_ADDR;
        end
      end
      S_ASSERT: begin
        if (i_mcclk_rising) begin
          w_state = S_DATA;
          if (!r_rw) begin
            w_d_out = r_wdata;
            w_d_oe  = 1'b1;
          end else begin
            w_d_oe = r_d_oe;
          end
        end else begin
          w_state = S_ASSERT;
        end
      end
      S_DATA: begin
        if (i_mcclk_falling) begin
          w_state = S_WAIT;
          w_cnt   = 8'd0;
          if (!r_rw) begin
            w_uds_n = w_lanes[1];
            w_lds_n = w_lanes[0];
          end else begin
            w_uds_n = r_uds_n;
          end
        end else begin
          w_state = S_DATA;
        end
      end
      S_WAIT: begin
        if (i_dtack_latch) begin
          w_dtack_seen = 1'b1;
        end else begin
          w_dtack_seen = r_dtack_seen;
        end
        // A DTACK arriving with the final watchdog strobe defers termination by one strobe.
        if (i_mcclk_falling) begin
          if (r_dtack_seen) begin
            w_state = S_END;
            w_as_n  = 1'b1;
            w_uds_n = 1'b1;
            w_lds_n = 1'b1;
            if (r_rw) begin
              w_rdata = i_m68k_d_in;
            end else begin
              w_rdata = r_rdata;
            end
          end else if ((r_cnt == TO_LAST) && !i_dtack_latch) begin
            w_state   = S_END;
            w_to_flag = 1'b1;
            w_as_n    = 1'b1;
            w_uds_n   = 1'b1;
            w_lds_n   = 1'b1;
            if (r_rw) begin
              w_rdata = 16'hFFFF;
            end else begin
              w_rdata = r_rdata;
            end
          end else if (r_cnt != 8'hFF) begin
            w_cnt = r_cnt + 8'd1;
          end else begin
            w_cnt = r_cnt;
          end
        end else begin
          w_state = S_WAIT;
        end
      end
      S_END: begin
        if (i_mcclk_rising) begin
          w_state      = S_IDLE;
          w_d_oe       = 1'b0;
          w_rw_out     = 1'b1;
          w_busy       = 1'b0;
          w_ack        = 1'b1;
          w_timeout    = r_to_flag;
          w_dtack_seen = 1'b0;
          w_to_flag    = 1'b0;
        end else begin
          w_state = S_END;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(negedge i_sysclk) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_rw         <= 1'b1;
      r_word       <= 1'b0;
      r_a0         <= 1'b0;
      r_wdata      <= 16'h0000;
      r_cnt        <= 8'd0;
      r_dtack_seen <= 1'b0;
      r_to_flag    <= 1'b0;
      r_busy       <= 1'b0;
      r_ack        <= 1'b0;
      r_timeout    <= 1'b0;
      r_rdata      <= 16'h0000;
      r_a          <= 23'd0;
      r_d_out      <= 16'h0000;
      r_d_oe       <= 1'b0;
      r_as_n       <= 1'b1;
      r_uds_n      <= 1'b1;
      r_lds_n      <= 1'b1;
      r_rw_out     <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_rw         <= w_rw;
      r_word       <= w_word;
      r_a0         <= w_a0;
      r_wdata      <= w_wdata;
      r_cnt        <= w_cnt;
      r_dtack_seen <= w_dtack_seen;
      r_to_flag    <= w_to_flag;
      r_busy       <= w_busy;
      r_ack        <= w_ack;
      r_timeout    <= w_timeout;
      r_rdata      <= w_rdata;
      r_a          <= w_a;
      r_d_out      <= w_d_out;
      r_d_oe       <= w_d_oe;
      r_as_n       <= w_as_n;
      r_uds_n      <= w_uds_n;
      r_lds_n      <= w_lds_n;
      r_rw_out     <= w_rw_out;
    end
  end

  assign o_busy       = r_busy;
  assign o_ack        = r_ack;
  assign o_timeout    = r_timeout;
  assign o_rdata      = r_rdata;
  assign o_m68k_a     = r_a;
  assign o_m68k_d_out = r_d_out;
  assign o_m68k_d_oe  = r_d_oe;
  assign o_m68k_as_n  = r_as_n;
  assign o_m68k_uds_n = r_uds_n;
  assign o_m68k_lds_n = r_lds_n;
  assign o_m68k_rw    = r_rw_out;

endmodule

// File: tb/tb_m68k_bus_cycle.sv
// Self-checking bench for m68k_bus_cycle: directed vector table, hand-written reset
// sequences, and randomized transactions scored against a transaction-level model.
module tb_m68k_bus_cycle;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rise = 1'b0, fall = 1'b0, dtack = 1'b0;
  logic        req = 1'b0, req_rw = 1'b1, req_word = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [15:0] req_wdata = 16'h0, d_in = 16'h0;
  logic        busy, ack, tmo, d_oe, as_n, uds_n, lds_n, rw;
  logic [15:0] rdata, d_out;
  logic [22:0] a;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_rdata = 16'h0;

  always #5 clk = ~clk;

  m68k_bus_cycle #(.TIMEOUT_CYCLES(TO)) dut (
    .i_sysclk(clk), .i_reset_n(rst_n),
    .i_mcclk_rising(rise), .i_mcclk_falling(fall), .i_dtack_latch(dtack),
    .i_req(req), .i_req_rw(req_rw), .i_req_word(req_word),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_busy(busy), .o_ack(ack), .o_timeout(tmo), .o_rdata(rdata), .o_m68k_a(a),
    .i_m68k_d_in(d_in), .o_m68k_d_out(d_out), .o_m68k_d_oe(d_oe),
    .o_m68k_as_n(as_n), .o_m68k_uds_n(uds_n), .o_m68k_lds_n(lds_n), .o_m68k_rw(rw)
  );

  typedef struct {
    bit          rw;
    bit          word;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          mode;   // 0 no DTACK, 1 DTACK between strobes, 2 DTACK with a falling strobe
    int          d;      // WAIT falling strobes seen before the DTACK pulse
    int          idle;   // SYSCLKs with REQ held before the accepting rising strobe
    bit          both;   // add the unexpected strobe wherever it must be ignored
    bit          drop;   // drop REQ right after acceptance
    int          exp_n;  // WAIT falling strobe that ends the bus cycle
    bit          exp_to;
    logic [15:0] exp_rdata;
    logic [1:0]  exp_sel; // {uds_n, lds_n}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit dt);
    rise = r; fall = f; dtack = dt;
    @(negedge clk);
    @(posedge clk);
    #1;
    rise = 1'b0; fall = 1'b0; dtack = 1'b0;
  endtask

  // Termination point from the watchdog and DTACK timing rules.
  task automatic model(input int mode, input int d, output int n, output bit to);
    if (mode == 0 || d + 1 > TO) begin
      n = TO; to = 1'b1;
    end else if (mode == 1) begin
      n = d + 1; to = 1'b0;
    end else begin
      n = d + 2; to = 1'b0;
    end
  endtask

  task automatic run_txn(input vec_t v);
    int term;
    logic [15:0] exp_rd;
    term = 2 + v.exp_n;
    req = 1'b1; req_rw = v.rw; req_word = v.word;
    req_addr = v.addr; req_wdata = v.wdata; d_in = v.din;
    for (int i = 0; i < v.idle; i++) begin
      step(1'b0, (i % 2) == 1, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_as", as_n, 1'b1);
    end
    step(1'b1, v.both, 1'b0);
    chk("acc_busy", busy, 1'b1);
    chk("acc_as", as_n, 1'b1);
    chk("acc_rw", rw, 1'b1);
    chk("acc_addr", a, v.addr[23:1]);
    if (v.drop) req = 1'b0;
    for (int k = 1; k <= term; k++) begin
      step(v.both, 1'b1, v.mode == 2 && k == 3 + v.d);
      if (k == 1) begin
        chk("f1_as", as_n, 1'b0);
        chk("f1_rw", rw, v.rw);
        chk("f1_lanes", {uds_n, lds_n}, v.rw ? v.exp_sel : 2'b11);
      end
      if (k == 2) chk("f2_lanes", {uds_n, lds_n}, v.exp_sel);
      if (k > 2 && k < term) chk("wait_as", as_n, 1'b0);
      if (k == term) begin
        chk("end_strobes", {as_n, uds_n, lds_n}, 3'b111);
        chk("end_busy", busy, 1'b1);
      end
      step(1'b0, 1'b0, v.mode == 1 && k == 2 + v.d);
      step(1'b1, v.both && (k < 2 || k == term), 1'b0);
      if (k == 1) begin
        chk("r1_doe", d_oe, !v.rw);
        if (!v.rw) chk("r1_dout", d_out, v.wdata);
      end
      if (k < term) chk("early_ack", ack, 1'b0);
      if (k == term) begin
        exp_rd = v.rw ? v.exp_rdata : last_rdata;
        chk("ack", ack, 1'b1);
        chk("timeout", tmo, v.exp_to);
        chk("rdata", rdata, exp_rd);
        chk("ack_busy", busy, 1'b0);
        chk("ack_doe_rw", {d_oe, rw}, 2'b01);
        last_rdata = exp_rd;
      end
    end
    req = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("ack_pulse", {ack, tmo}, 2'b00);
  endtask

  vec_t tbl[8];

  initial begin
    vec_t rv;
    // rw word addr wdata din mode d idle both drop | n to rdata sel
    tbl[0] = '{1'b1, 1'b1, 24'h00DFF000, 16'h0000, 16'h1234, 1, 0, 0, 1'b0, 1'b0, 1, 1'b0, 16'h1234, 2'b00};
    tbl[1] = '{1'b0, 1'b0, 24'h000001, 16'h00AB, 16'h7777, 1, 0, 0, 1'b0, 1'b0, 1, 1'b0, 16'h0000, 2'b10};
    tbl[2] = '{1'b1, 1'b1, 24'h00DFF000, 16'h0000, 16'hBEEF, 1, 3, 0, 1'b0, 1'b0, 4, 1'b0, 16'hBEEF, 2'b00};
    tbl[3] = '{1'b1, 1'b1, 24'h00A000, 16'h0000, 16'h4321, 0, 0, 0, 1'b0, 1'b0, 4, 1'b1, 16'hFFFF, 2'b00};
    tbl[4] = '{1'b1, 1'b0, 24'h123456, 16'h0000, 16'h5A5A, 1, 1, 10, 1'b0, 1'b0, 2, 1'b0, 16'h5A5A, 2'b01};
    tbl[5] = '{1'b1, 1'b1, 24'h000200, 16'h0000, 16'hC0DE, 2, 3, 0, 1'b0, 1'b0, 5, 1'b0, 16'hC0DE, 2'b00};
    tbl[6] = '{1'b0, 1'b1, 24'hFFFFFE, 16'h9876, 16'h1111, 0, 0, 1, 1'b1, 1'b0, 4, 1'b1, 16'h0000, 2'b00};
    tbl[7] = '{1'b1, 1'b0, 24'h000003, 16'h0000, 16'h00C3, 2, 0, 2, 1'b1, 1'b1, 2, 1'b0, 16'h00C3, 2'b10};

    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_strobes", {as_n, uds_n, lds_n, rw}, 4'b1111);
    chk("rst_ctl", {d_oe, ack, tmo, busy}, 4'b0000);
    chk("rst_dout", d_out, 16'h0000);
    chk("rst_addr", a, 23'h0);
    chk("rst_rdata", rdata, 16'h0000);
    rst_n = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset while a write sits in WAIT with its strobes asserted.
    req = 1'b1; req_rw = 1'b0; req_word = 1'b1; req_addr = 24'h000100; req_wdata = 16'h5555;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("pre_rst_wait", {as_n, uds_n, lds_n, d_oe}, 4'b0001);
    rst_n = 1'b0;
    req = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("midrst_strobes", {as_n, uds_n, lds_n, rw}, 4'b1111);
    chk("midrst_ctl", {d_oe, busy, ack, tmo}, 4'b0000);
    chk("midrst_data", {d_out, rdata}, 32'h0);
    rst_n = 1'b1;
    last_rdata = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      step(i % 2 == 0, i % 2 == 1, 1'b1);
      chk("postrst_quiet", {ack, busy, as_n}, 3'b001);
    end

    for (int t = 0; t < 40; t++) begin
      rv.rw    = $urandom_range(0, 1);
      rv.word  = $urandom_range(0, 1);
      rv.addr  = 24'($urandom);
      rv.wdata = 16'($urandom);
      rv.din   = 16'($urandom);
      rv.mode  = $urandom_range(0, 2);
      rv.d     = $urandom_range(0, 5);
      rv.idle  = $urandom_range(0, 3);
      rv.both  = $urandom_range(0, 1);
      rv.drop  = $urandom_range(0, 1);
      model(rv.mode, rv.d, rv.exp_n, rv.exp_to);
      rv.exp_rdata = rv.exp_to ? 16'hFFFF : rv.din;
      rv.exp_sel   = rv.word ? 2'b00 : (rv.addr[0] ? 2'b10 : 2'b01);
      run_txn(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
